// File: rtl/uart_core_if.sv
// CPU-side register strobes and status of the UART core.
// Serial pins stay plain ports on the core.
interface uart_core_if;
    logic [15:0] d;
    logic        wrtx;
    logic        wrbaud;
    logic        rd;
    logic [7:0]  q;
    logic        dv;
    logic        fe;
    logic        ove;
    logic        tend;
    logic        thre;

    modport master (
        output d, wrtx, wrbaud, rd,
        input  q, dv, fe, ove, tend, thre
    );

    modport slave (
        input  d, wrtx, wrbaud, rd,
        output q, dv, fe, ove, tend, thre
    );
endinterface

// File: rtl/uart_core.sv
// Full-duplex 8N1 UART with a shared programmable baud divider.
// Independent TX and RX state machines, each with its own bit counter.
module uart_core #(
    parameter int unsigned BAUDBITS = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rxd,
    output logic        txd,
    uart_core_if.slave  bus
);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic [BAUDBITS-1:0] div;

    tx_state_t           tx_state;
    logic [BAUDBITS-1:0] tx_cnt;
    logic [2:0]          tx_bit;
    logic [7:0]          tx_hold;
    logic [7:0]          tx_shift;
    logic                txd_r;
    logic                thre_r;
    logic                tend_r;

    rx_state_t           rx_state;
    logic [1:0]          rx_sync;
    logic                rx_s;
    logic [BAUDBITS-1:0] rx_cnt;
    logic [BAUDBITS-1:0] rx_half;
    logic [2:0]          rx_bit;
    logic [7:0]          rx_shift;
    logic [7:0]          q_r;
    logic                dv_r;
    logic                fe_r;
    logic                ove_r;
    logic                unused_d;

    assign txd      = txd_r;
    assign bus.q    = q_r;
    assign bus.dv   = dv_r;
    assign bus.fe   = fe_r;
    assign bus.ove  = ove_r;
    assign bus.tend = tend_r;
    assign bus.thre = thre_r;
    assign unused_d = ^bus.d;

    // Counters read div only on reload, so a new divider never truncates a bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div <= '0;
        end else if (bus.wrbaud) begin
            div <= bus.d[BAUDBITS-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_hold  <= '0;
            tx_shift <= '0;
            txd_r    <= 1'b1;
            thre_r   <= 1'b1;
            tend_r   <= 1'b1;
        end else begin
            if (bus.wrtx && thre_r) begin
                tx_hold <= bus.d[7:0];
                thre_r  <= 1'b0;
            end
            case (tx_state)
                TX_IDLE: begin
                    if (!thre_r) begin
                        tx_shift <= tx_hold;
                        thre_r   <= 1'b1;
                        tend_r   <= 1'b0;
                        txd_r    <= 1'b0;
                        tx_cnt   <= div;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt == '0) begin
                        txd_r    <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        tx_bit   <= '0;
                        tx_cnt   <= div;
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt - BAUDBITS'(1);
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == '0) begin
                        tx_cnt <= div;
                        if (tx_bit == 3'd7) begin
                            txd_r    <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            txd_r    <= tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            tx_bit   <= tx_bit + 3'd1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - BAUDBITS'(1);
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == '0) begin
                        // A waiting byte starts immediately, keeping frames gapless.
                        if (!thre_r) begin
                            tx_shift <= tx_hold;
                            thre_r   <= 1'b1;
                            txd_r    <= 1'b0;
                            tx_cnt   <= div;
                            tx_state <= TX_START;
                        end else begin
                            tend_r   <= 1'b1;
                            tx_state <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - BAUDBITS'(1);
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_sync <= 2'b11;
        end else begin
            rx_sync <= {rx_sync[0], rxd};
        end
    end

    assign rx_s    = rx_sync[1];
    assign rx_half = BAUDBITS'(({1'b0, div} + 1'b1) >> 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            q_r      <= '0;
            dv_r     <= 1'b0;
            fe_r     <= 1'b0;
            ove_r    <= 1'b0;
        end else begin
            if (bus.rd) begin
                dv_r  <= 1'b0;
                fe_r  <= 1'b0;
                ove_r <= 1'b0;
            end
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_s) begin
                        rx_cnt   <= rx_half;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt == '0) begin
                        if (rx_s) begin
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_cnt   <= div;
                            rx_bit   <= '0;
                            rx_state <= RX_DATA;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - BAUDBITS'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == '0) begin
                        rx_shift <= {rx_s, rx_shift[7:1]};
                        rx_cnt   <= div;
                        if (rx_bit == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            rx_bit <= rx_bit + 3'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - BAUDBITS'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == '0) begin
                        // Completion overrides a coincident rd; overrun only without rd.
                        q_r   <= rx_shift;
                        dv_r  <= 1'b1;
                        fe_r  <= ~rx_s;
                        if (dv_r && !bus.rd) begin
                            ove_r <= 1'b1;
                        end
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt - BAUDBITS'(1);
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core: table-driven RX vectors, directed TX/RX
// corner sequences and randomized frames checked against a frame-level model.
module tb_uart_core;

    localparam int unsigned BB = 12;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic rxd = 1'b1;
    logic txd;

    int errors = 0;
    int checks = 0;
    int lat = 0;

    uart_core_if bus ();

    uart_core #(.BAUDBITS(BB)) dut (
        .clk   (clk),
        .reset (reset),
        .rxd   (rxd),
        .txd   (txd),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       do_rd;
        logic [7:0] exp_q;
        logic       exp_fe;
        logic       exp_ove;
    } rx_vec_t;

    rx_vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_baud(input int v);
        bus.d      = 16'(v);
        bus.wrbaud = 1'b1;
        @(negedge clk);
        bus.wrbaud = 1'b0;
    endtask

    task automatic write_tx(input logic [7:0] b);
        bus.d    = {8'h00, b};
        bus.wrtx = 1'b1;
        @(negedge clk);
        bus.wrtx = 1'b0;
    endtask

    task automatic pulse_rd;
        bus.rd = 1'b1;
        @(negedge clk);
        bus.rd = 1'b0;
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop, input int p);
        logic [7:0] bits;
        bits = b;
        rxd = 1'b0;
        clocks(p);
        for (int i = 0; i < 8; i++) begin
            rxd = bits[i];
            clocks(p);
        end
        rxd = stop;
        clocks(p);
        rxd = 1'b1;
    endtask

    // Called on the first negedge where txd should be low; every clock of
    // every bit period is compared against the ideal 8N1 waveform.
    task automatic tx_expect(input logic [7:0] b, input int p, input string tag);
        logic [9:0] frame;
        logic       act;
        logic       bad;
        logic       busy_bad;
        frame    = {1'b1, b, 1'b0};
        busy_bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bad = 1'b0;
            act = frame[i];
            for (int k = 0; k < p; k++) begin
                if (!bad && txd !== frame[i]) begin
                    bad = 1'b1;
                    act = txd;
                end
                if (bus.tend !== 1'b0) busy_bad = 1'b1;
                @(negedge clk);
            end
            chk($sformatf("%s_bit%0d", tag, i), act, frame[i]);
        end
        chk({tag, "_tend_busy"}, busy_bad, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] prev_q;
        logic [7:0] m_q;
        logic       m_dv, m_fe, m_ove;
        logic [7:0] tb_byte, rb_byte;
        logic       stop_bit;
        int         p;

        bus.d = '0; bus.wrtx = 1'b0; bus.wrbaud = 1'b0; bus.rd = 1'b0;

        vecs[0] = '{8'hC4, 1'b1, 1'b1, 8'hC4, 1'b0, 1'b0};
        vecs[1] = '{8'h7E, 1'b0, 1'b1, 8'h7E, 1'b1, 1'b0};
        vecs[2] = '{8'h11, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0};
        vecs[3] = '{8'h22, 1'b1, 1'b0, 8'h22, 1'b0, 1'b1};
        vecs[4] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0};

        clocks(3);
        chk("rst_txd", txd, 1'b1);
        chk("rst_q", bus.q, 8'h00);
        chk("rst_dv", bus.dv, 1'b0);
        chk("rst_fe", bus.fe, 1'b0);
        chk("rst_ove", bus.ove, 1'b0);
        chk("rst_thre", bus.thre, 1'b1);
        chk("rst_tend", bus.tend, 1'b1);
        reset = 1'b1;
        clocks(2);

        // TX latency, waveform and tend timing
        set_baud(9);
        write_tx(8'h55);
        chk("t1_txd_not_yet", txd, 1'b1);
        chk("t1_thre_clr", bus.thre, 1'b0);
        @(negedge clk);
        chk("t1_txd_fall", txd, 1'b0);
        chk("t1_thre_set", bus.thre, 1'b1);
        tx_expect(8'h55, 10, "t1");
        chk("t1_tend_end", bus.tend, 1'b1);
        chk("t1_txd_idle", txd, 1'b1);

        // Back-to-back frames and ignored write while holding is full
        clocks(5);
        write_tx(8'hA3);
        @(negedge clk);
        fork
            begin
                tx_expect(8'hA3, 10, "t2a");
                tx_expect(8'h0F, 10, "t2b");
            end
            begin
                clocks(20);
                write_tx(8'h0F);
                chk("t2_thre_full", bus.thre, 1'b0);
                clocks(10);
                write_tx(8'h99);
                chk("t2_thre_ignored", bus.thre, 1'b0);
            end
        join
        chk("t2_tend", bus.tend, 1'b1);
        chk("t2_thre_end", bus.thre, 1'b1);
        clocks(30);
        chk("t2_no_third", txd, 1'b1);

        // RX vector table
        prev_q = 8'h00;
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].do_rd) begin
                pulse_rd;
                chk($sformatf("v%0d_rd_dv", i), bus.dv, 1'b0);
                chk($sformatf("v%0d_rd_fe", i), bus.fe, 1'b0);
                chk($sformatf("v%0d_rd_ove", i), bus.ove, 1'b0);
                chk($sformatf("v%0d_rd_q_held", i), bus.q, prev_q);
            end
            if (i == 0) begin
                fork
                    rx_send(vecs[i].data, vecs[i].stop, 10);
                    begin
                        lat = 0;
                        while (bus.dv !== 1'b1 && lat < 150) begin
                            @(negedge clk);
                            lat++;
                        end
                    end
                join
                chk("rx_latency_window", (lat >= 90 && lat <= 105), 1'b1);
            end else begin
                rx_send(vecs[i].data, vecs[i].stop, 10);
            end
            clocks(20);
            chk($sformatf("v%0d_q", i), bus.q, vecs[i].exp_q);
            chk($sformatf("v%0d_dv", i), bus.dv, 1'b1);
            chk($sformatf("v%0d_fe", i), bus.fe, vecs[i].exp_fe);
            chk($sformatf("v%0d_ove", i), bus.ove, vecs[i].exp_ove);
            prev_q = vecs[i].exp_q;
        end

        // rd coinciding with completion of the second of two back-to-back frames
        pulse_rd;
        fork
            begin
                rx_send(8'h11, 1'b1, 10);
                rx_send(8'h22, 1'b1, 10);
            end
            begin
                clocks(100 + lat - 1);
                chk("t5b_dv_before", bus.dv, 1'b1);
                bus.rd = 1'b1;
                @(negedge clk);
                bus.rd = 1'b0;
            end
        join
        clocks(20);
        chk("t5b_q", bus.q, 8'h22);
        chk("t5b_dv", bus.dv, 1'b1);
        chk("t5b_ove", bus.ove, 1'b0);
        chk("t5b_fe", bus.fe, 1'b0);

        // Short glitch is a false start; receiver still works afterwards
        pulse_rd;
        rxd = 1'b0;
        clocks(3);
        rxd = 1'b1;
        clocks(20);
        chk("t6_glitch_dv", bus.dv, 1'b0);
        chk("t6_glitch_fe", bus.fe, 1'b0);
        chk("t6_glitch_ove", bus.ove, 1'b0);
        rx_send(8'hA5, 1'b1, 10);
        clocks(20);
        chk("t6_after_q", bus.q, 8'hA5);
        chk("t6_after_dv", bus.dv, 1'b1);

        // Asynchronous reset in the middle of a TX frame
        write_tx(8'h00);
        @(negedge clk);
        write_tx(8'hFF);
        clocks(30);
        chk("t6_txd_low_before", txd, 1'b0);
        chk("t6_thre_full_before", bus.thre, 1'b0);
        #1 reset = 1'b0;
        #1;
        chk("t6_rst_txd", txd, 1'b1);
        chk("t6_rst_thre", bus.thre, 1'b1);
        chk("t6_rst_tend", bus.tend, 1'b1);
        chk("t6_rst_dv", bus.dv, 1'b0);
        chk("t6_rst_q", bus.q, 8'h00);
        clocks(3);
        reset = 1'b1;
        clocks(2);

        // Randomized concurrent TX/RX against a frame-level model
        m_q = 8'h00; m_dv = 1'b0; m_fe = 1'b0; m_ove = 1'b0;
        for (int it = 0; it < 8; it++) begin
            p        = int'($urandom_range(4, 13));
            tb_byte  = 8'($urandom);
            rb_byte  = 8'($urandom);
            stop_bit = ($urandom_range(0, 3) != 0);
            set_baud(p - 1);
            if ($urandom_range(0, 1) == 1) begin
                pulse_rd;
                m_dv = 1'b0; m_fe = 1'b0; m_ove = 1'b0;
            end
            fork
                begin
                    write_tx(tb_byte);
                    @(negedge clk);
                    tx_expect(tb_byte, p, $sformatf("rnd%0d_tx", it));
                end
                begin
                    rx_send(rb_byte, stop_bit, p);
                    clocks(2 * p);
                end
            join
            m_ove = m_ove | m_dv;
            m_dv  = 1'b1;
            m_q   = rb_byte;
            m_fe  = ~stop_bit;
            chk($sformatf("rnd%0d_q", it), bus.q, m_q);
            chk($sformatf("rnd%0d_dv", it), bus.dv, m_dv);
            chk($sformatf("rnd%0d_fe", it), bus.fe, m_fe);
            chk($sformatf("rnd%0d_ove", it), bus.ove, m_ove);
            chk($sformatf("rnd%0d_tend", it), bus.tend, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
- Byte-oriented full-duplex UART core (8 data bits, no parity, 1 stop bit, LSB first) with a programmable baud divider.
- Used as the memory-mapped serial peripheral of the RISC-V SoC; the bus glue decodes the strobes wrtx, wrbaud and rd.
- Status outputs dv and thre feed the interrupt controller directly.

Parameters:
BAUDBITS, 12, width of the baud divider register; bit period = divider+1 clocks.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset (asserted at 0)
rxd  input  1  serial receive line, asynchronous, idle high
txd  output  1  serial transmit line, idle high
d  input  16  write data; d[7:0] is the TX byte, d[BAUDBITS-1:0] is the divider
wrtx  input  1  1-cycle strobe: load d[7:0] into TX holding register
wrbaud  input  1  1-cycle strobe: load divider from d[BAUDBITS-1:0]
rd  input  1  1-cycle strobe: CPU has read the RX data register
q  output  8  last received byte
dv  output  1  received data valid
fe  output  1  framing error (stop bit sampled 0)
ove  output  1  overrun (frame completed while dv=1)
tend  output  1  transmitter completely idle (holding empty and shifter idle)
thre  output  1  TX holding register empty

Behaviour:
- Reset (reset=0, asynchronous): txd=1, q=0, dv=0, fe=0, ove=0, thre=1, tend=1, divider=0. Both state machines go to IDLE, and any frame in progress is abandoned. Software must program a divider of at least 3 before use.
- Baud timing:
  - TX and RX each own a bit counter that reloads to the divider value and counts down; one bit period = divider+1 clocks.
  - wrbaud updates the divider at the next edge; the new value takes effect at the next counter reload, so the current bit is not cut short.
- TX holding register:
  - wrtx with thre=1 latches d[7:0] and clears thre at the edge.
  - wrtx with thre=0 is ignored; no data is overwritten and no flag is set.
- TX state machine, states IDLE, START, DATA(0..7), STOP:
  - In IDLE with the holding register full, the byte transfers to the shifter on the next edge. thre returns to 1, tend=0, and txd drives 0 for one bit period (START).
  - Latency: wrtx sampled at edge N, so txd falls after edge N+1.
  - DATA shifts bits 0..7, one per bit period, LSB first. STOP drives txd=1 for one bit period.
  - At the end of STOP: if the holding register is full, go straight to START with no idle gap; otherwise go to IDLE and set tend=1.
  - Frame length = 10×(divider+1) clocks.
- RX path:
  - rxd passes through a 2-flop synchronizer.
  - States: IDLE, START, DATA(0..7), STOP.
  - IDLE: a synchronized 0 enters START and loads a half-period count of floor((divider+1)/2).
  - START: at the half point the line is resampled. If it is 1, the start was false and the machine returns to IDLE with no flags. Otherwise, run full-period counts and sample the 8 data bits at bit centers, LSB first.
  - STOP: sample at bit center. On completion: q <= byte, dv <= 1, fe <= (stop==0). If dv was already 1 and no rd occurs in the same cycle, ove <= 1.
  - The machine returns to IDLE right after the stop sample, so back-to-back frames are received.
- rd strobe:
  - Clears dv, fe and ove at the next edge; q is held.
  - If rd coincides with a frame completion, the new frame wins: dv=1, q=new byte, fe from the new frame, and ove is not set.
- TX and RX are fully independent; simultaneous wrtx, wrbaud and rd are all honoured in the same cycle.
- Reset asserted mid-frame forces txd=1 immediately (asynchronous) and discards any partially received byte.

Test Plan:
1. Reset, then wrbaud d=9 (10 clk/bit), then wrtx d=0x55. Required: txd low 1 clk after the strobe edge; pattern 0,1,0,1,0,1,0,1,0,1 with 10 clocks per bit; thre=1 one cycle after the strobe; tend=1 exactly 100 clocks after txd fell.
2. Divider 9; wrtx 0xA3, then wrtx 0x0F while the first byte is in DATA. Required: two frames with no idle gap; a third wrtx while thre=0 is ignored.
3. Divider 9; drive rxd with frame 0xC4 (stop=1) at 10 clk/bit. Required: q=0xC4, dv=1, fe=0, ove=0; pulse rd gives dv=0 and q still 0xC4.
4. Drive a frame with stop bit 0, data 0x7E. Required: q=0x7E, dv=1, fe=1; rd clears fe and dv.
5. Receive 0x11, then 0x22 without rd. Required: q=0x22, dv=1, ove=1. Repeat with rd asserted on the completion cycle of 0x22: ove stays 0 and dv=1.
6. Glitch rxd low for 3 clocks (divider 9). Required: no dv and no flags; RX returns to IDLE. Assert reset mid-TX frame: txd=1 at once, thre=1, tend=1.
